clk_div_multi: RTL and testbench

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_multi.sv | 86 ++++++++
 tb/tb_clk_div_multi.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider
// Shadowed divisors are applied only on a wrap, while disabled, or on sync, so output periods never glitch.
module clk_div_multi #(
  parameter int NCH = 3,
  parameter int W = 28,
  parameter logic [NCH*W-1:0] DIV_DEFAULT = {28'd100000, 28'd1000000, 28'd12500000},
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clock_in,
  input  logic           rst,
  input  logic [NCH-1:0] enable,
  input  logic           sync,
  input  logic           cfg_we,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [W-1:0]   cfg_div,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] cfg_pending,
  output logic           cfg_err
);

  logic [W-1:0]   cnt [NCH];
  logic [W-1:0]   act [NCH];
  logic [W-1:0]   shd [NCH];
  logic [NCH-1:0] pend;
  logic           cfg_ok;
  logic [NCH-1:0] wr_hit;

  assign cfg_ok      = (32'(cfg_ch) < NCH);
  assign cfg_pending = pend;

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_hit[i] = cfg_we && cfg_ok && (32'(cfg_ch) == 32'(i));
    end
  end

  always_ff @(posedge clock_in or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
        act[i] <= DIV_DEFAULT[i*W +: W];
        shd[i] <= DIV_DEFAULT[i*W +: W];
      end
      pend    <= '0;
      clk_out <= '0;
      tick    <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      for (int i = 0; i < NCH; i++) begin
        tick[i] <= 1'b0;
        if (sync) begin
          cnt[i]     <= '0;
          clk_out[i] <= 1'b0;
          if (pend[i]) begin
            act[i]  <= shd[i];
            pend[i] <= 1'b0;
          end
        end else if (!enable[i]) begin
          if (pend[i]) begin
            act[i]  <= shd[i];
            pend[i] <= 1'b0;
          end
        end else if (cnt[i] == act[i]) begin
          cnt[i]     <= '0;
          clk_out[i] <= ~clk_out[i];
          tick[i]    <= 1'b1;
          if (pend[i]) begin
            act[i]  <= shd[i];
            pend[i] <= 1'b0;
          end
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
        // A write lands after any apply above, so it always waits for the next wrap.
        if (wr_hit[i]) begin
          shd[i]  <= cfg_div;
          pend[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - directed table and sequence checks for clk_div_multi
module tb_clk_div_multi;

  logic       clock_in = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] enable = 3'b111;
  logic       sync = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = 2'd0;
  logic [7:0] cfg_div = 8'd0;
  logic [2:0] clk_out;
  logic [2:0] tick;
  logic [2:0] cfg_pending;
  logic       cfg_err;

  int total = 0;
  int bad = 0;
  int n;

  typedef struct {
    logic [2:0] en;
    logic       we;
    logic [1:0] ch;
    logic [7:0] div;
    logic [2:0] clk;
    logic [2:0] tk;
    logic [2:0] pend;
    logic       err;
  } vec_t;

  vec_t tv[22];

  clk_div_multi #(.NCH(3), .W(8), .DIV_DEFAULT({8'd0, 8'd1, 8'd3})) dut (
    .clock_in(clock_in), .rst(rst), .enable(enable), .sync(sync),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .clk_out(clk_out), .tick(tick), .cfg_pending(cfg_pending), .cfg_err(cfg_err)
  );

  always #5 clock_in = ~clock_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic idle_inputs();
    enable = 3'b111;
    sync = 1'b0;
    cfg_we = 1'b0;
    cfg_ch = 2'd0;
    cfg_div = 8'd0;
  endtask

  // Asserts reset between edges and checks outputs clear without any clock edge.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b0;
    idle_inputs();
    #1;
    check({tag, " rst clk_out"}, 32'(clk_out), 32'h0);
    check({tag, " rst tick"}, 32'(tick), 32'h0);
    check({tag, " rst pending"}, 32'(cfg_pending), 32'h0);
    check({tag, " rst err"}, 32'(cfg_err), 32'h0);
    @(negedge clock_in);
    rst = 1'b1;
  endtask

  task automatic apply_rows(input int first, input int last);
    for (int r = first; r <= last; r++) begin
      enable = tv[r].en;
      cfg_we = tv[r].we;
      cfg_ch = tv[r].ch;
      cfg_div = tv[r].div;
      step();
      check($sformatf("row%0d clk_out", r + 1), 32'(clk_out), 32'(tv[r].clk));
      check($sformatf("row%0d tick", r + 1), 32'(tick), 32'(tv[r].tk));
      check($sformatf("row%0d pending", r + 1), 32'(cfg_pending), 32'(tv[r].pend));
      check($sformatf("row%0d err", r + 1), 32'(cfg_err), 32'(tv[r].err));
    end
    idle_inputs();
  endtask

  task automatic wait_tick(input int ch, input int limit, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!tick[ch] && cnt < limit);
  endtask

  initial begin
    // Rows are edges 1..22 after reset release: {en, we, ch, div, clk_out, tick, pending, err}.
    tv[0]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b100, 3'b100, 3'b000, 1'b0};
    tv[1]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b010, 3'b110, 3'b000, 1'b0};
    tv[2]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b110, 3'b100, 3'b000, 1'b0};
    tv[3]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b001, 3'b111, 3'b000, 1'b0};
    tv[4]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b101, 3'b100, 3'b000, 1'b0};
    tv[5]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b011, 3'b110, 3'b000, 1'b0};
    tv[6]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 3'b100, 3'b000, 1'b0};
    tv[7]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b000, 3'b111, 3'b000, 1'b0};
    tv[8]  = '{3'b111, 1'b1, 2'd3, 8'd55, 3'b100, 3'b100, 3'b000, 1'b1};
    tv[9]  = '{3'b111, 1'b1, 2'd0, 8'd9, 3'b010, 3'b110, 3'b001, 1'b0};
    tv[10] = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b110, 3'b100, 3'b001, 1'b0};
    tv[11] = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b001, 3'b111, 3'b000, 1'b0};
    tv[12] = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b101, 3'b100, 3'b000, 1'b0};
    tv[13] = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b011, 3'b110, 3'b000, 1'b0};
    tv[14] = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 3'b100, 3'b000, 1'b0};
    tv[15] = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b001, 3'b110, 3'b000, 1'b0};
    tv[16] = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b101, 3'b100, 3'b000, 1'b0};
    tv[17] = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b011, 3'b110, 3'b000, 1'b0};
    tv[18] = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 3'b100, 3'b000, 1'b0};
    tv[19] = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b001, 3'b110, 3'b000, 1'b0};
    tv[20] = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b101, 3'b100, 3'b000, 1'b0};
    tv[21] = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b010, 3'b111, 3'b000, 1'b0};

    idle_inputs();
    #1;
    check("power-on clk_out", 32'(clk_out), 32'h0);
    check("power-on pending", 32'(cfg_pending), 32'h0);
    repeat (2) @(posedge clock_in);
    @(negedge clock_in);
    rst = 1'b1;

    // Default rates, bad channel write, ch0 divisor change at the next wrap.
    apply_rows(0, 21);

    // Pending ch0 divisor applied by sync; ch1 write coincident with sync.
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd1;
    step();
    idle_inputs();
    check("pre-sync pending", 32'(cfg_pending), 32'h1);
    check("pre-sync clk_out", 32'(clk_out), 32'h6);
    sync = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd2;
    step();
    idle_inputs();
    check("sync clk_out", 32'(clk_out), 32'h0);
    check("sync tick", 32'(tick), 32'h0);
    check("sync pending", 32'(cfg_pending), 32'h2);
    step();
    check("sync+1 clk_out", 32'(clk_out), 32'h4);
    check("sync+1 tick", 32'(tick), 32'h4);
    step();
    check("sync+2 clk_out", 32'(clk_out), 32'h3);
    check("sync+2 tick", 32'(tick), 32'h7);
    check("sync+2 pending", 32'(cfg_pending), 32'h0);
    wait_tick(1, 20, n);
    check("ch1 div2 half-period", 32'(n), 32'd3);
    check("ch1 div2 clk_out", 32'(clk_out[1]), 32'h0);

    // Async reset mid-run, default behaviour recurs, then ch1 freeze with disabled apply.
    do_reset("mid-run");
    apply_rows(0, 3);
    step();
    for (int j = 0; j < 5; j++) begin
      enable = 3'b101;
      if (j == 1) begin
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3;
      end
      step();
      cfg_we = 1'b0;
      check($sformatf("freeze%0d ch1", j), {30'd0, clk_out[1], tick[1]}, 32'h0);
      if (j == 1) check("disabled write pending", 32'(cfg_pending), 32'h2);
      if (j == 2) check("disabled apply pending", 32'(cfg_pending), 32'h0);
    end
    idle_inputs();
    wait_tick(1, 20, n);
    check("ch1 resume count", 32'(n), 32'd3);
    check("ch1 resume clk_out", 32'(clk_out[1]), 32'h1);

    // Write landing on the same edge as a wrap that consumes an older pending value.
    do_reset("pre-wrap");
    step();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5;
    step();
    idle_inputs();
    check("ch0 first write pending", 32'(cfg_pending), 32'h1);
    step();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2;
    step();
    idle_inputs();
    check("wrap+write tick", 32'(tick[0]), 32'h1);
    check("wrap+write pending", 32'(cfg_pending[0]), 32'h1);
    wait_tick(0, 30, n);
    check("ch0 div5 half-period", 32'(n), 32'd6);
    check("ch0 div5 wrap pending", 32'(cfg_pending), 32'h0);
    wait_tick(0, 30, n);
    check("ch0 div2 half-period", 32'(n), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
